// File: rtl/grid_pkg.sv
// Shared constants, state encoding and cell-address helper for the cursor-paint grid controller.
package grid_pkg;

  localparam int COLS   = 96;
  localparam int ROWS   = 54;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 13;
  localparam int CELLS  = COLS * ROWS;
  localparam int ROW_W  = 6;
  localparam int COL_W  = 7;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_P_RD,
    ST_P_CHK,
    ST_P_WR,
    ST_IDLE
  } ctrl_state_t;

  // Row-major cell index; the multiply is by a constant so it reduces to shifts and adds.
  function automatic logic [ADDR_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers a synchronized button level and flags its rising edge for one cycle.
module btn_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/grid_paint_ctrl.sv
// Cursor-paint sequencer: button moves, read-modify-write paint, clear sweep, and
// scanner-priority sharing of the single-port cell RAM.
//
// state    | meaning
// ST_CLEAR | writing 0 at sweep_addr, one cell per cycle
// ST_P_RD  | issuing read of the cell under the cursor
// ST_P_CHK | inspecting read data; already set -> done, else paint
// ST_P_WR  | writing 1 under the cursor and counting it
// ST_IDLE  | waiting for a button edge, no RAM access
module grid_paint_ctrl
  import grid_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              btn_right,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_clear,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_vld,
  output logic              disp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic [CNT_W-1:0]  cell_count,
  output logic              busy
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] cell_addr;
  logic              right_edge;
  logic              up_edge;
  logic              down_edge;
  logic              clear_edge;
  logic [COL_W-1:0]  col_inc;
  logic [ROW_W-1:0]  row_inc;
  logic [ROW_W-1:0]  row_dec;

  btn_edge u_edge_right (.CLK(CLK), .RESET(RESET), .level(btn_right), .pulse(right_edge));
  btn_edge u_edge_up    (.CLK(CLK), .RESET(RESET), .level(btn_up),    .pulse(up_edge));
  btn_edge u_edge_down  (.CLK(CLK), .RESET(RESET), .level(btn_down),  .pulse(down_edge));
  btn_edge u_edge_clear (.CLK(CLK), .RESET(RESET), .level(btn_clear), .pulse(clear_edge));

  assign cell_addr = cell_index(cur_row, cur_col);
  assign col_inc   = (cur_col == COL_W'(COLS - 1)) ? '0 : cur_col + 1'b1;
  assign row_inc   = (cur_row == ROW_W'(ROWS - 1)) ? '0 : cur_row + 1'b1;
  assign row_dec   = (cur_row == '0) ? ROW_W'(ROWS - 1) : cur_row - 1'b1;

  assign disp_gnt  = disp_req;
  assign disp_data = mem_rdata;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      cur_row    <= '0;
      cur_col    <= '0;
      cell_count <= '0;
      disp_vld   <= 1'b0;
    end else begin
      disp_vld <= disp_req;
      if (disp_req) begin
        // The scanner read lands on mem_rdata next cycle, so a pending check must re-read.
        if (state == ST_P_CHK) state <= ST_P_RD;
      end else begin
        case (state)
          ST_CLEAR: begin
            if (sweep_addr == ADDR_W'(CELLS - 1)) begin
              sweep_addr <= '0;
              cell_count <= '0;
              state      <= ST_P_RD;
            end else begin
              sweep_addr <= sweep_addr + 1'b1;
            end
          end
          ST_P_RD:  state <= ST_P_CHK;
          ST_P_CHK: state <= mem_rdata ? ST_IDLE : ST_P_WR;
          ST_P_WR: begin
            cell_count <= cell_count + 1'b1;
            state      <= ST_IDLE;
          end
          ST_IDLE: begin
            if (clear_edge) begin
              sweep_addr <= '0;
              state      <= ST_CLEAR;
            end else if (right_edge) begin
              cur_col <= col_inc;
              state   <= ST_P_RD;
            end else if (up_edge) begin
              cur_row <= row_inc;
              state   <= ST_P_RD;
            end else if (down_edge) begin
              cur_row <= row_dec;
              state   <= ST_P_RD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cell_addr;
    mem_wdata = 1'b0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else begin
      case (state)
        ST_CLEAR: begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = sweep_addr;
        end
        ST_P_RD: mem_en = 1'b1;
        ST_P_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
